// File: rtl/fifo_access_scheduler.sv
// Shares the single write port of an 8x8 FIFO between two producers and interleaves
// those writes with consumer reads, issuing at most one FIFO enable per cycle.
module fifo_access_scheduler (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       rd_req,
    output logic       rd_ack,
    output logic       rd_valid,
    input  logic       fifo_full,
    input  logic       fifo_empty,
    output logic       fifo_wn,
    output logic [7:0] fifo_din,
    output logic       fifo_rn,
    output logic [3:0] level
);

    typedef enum logic {W_PRI = 1'b0, R_PRI = 1'b1} op_state_t;

    op_state_t state, next_state;
    logic      rr;
    logic      wr_elig, rd_elig;
    logic      do_wr, do_rd, pick1;

    assign wr_elig = (req0 | req1) & ~fifo_full;
    assign rd_elig = rd_req & ~fifo_empty;

    // NOTE: every signal gets a default at the top of the block so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        do_wr      = 1'b0;
        do_rd      = 1'b0;
        pick1      = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        fifo_wn    = 1'b0;
        fifo_rn    = 1'b0;
        rd_ack     = 1'b0;
        fifo_din   = 8'h00;
        next_state = state;

        if (!reset) begin
            do_wr = wr_elig & (~rd_elig | (state == W_PRI));
            do_rd = rd_elig & ~do_wr;
            pick1 = req1 & (~req0 | rr);

            if (do_wr) begin
                fifo_wn    = 1'b1;
                gnt0       = ~pick1;
                gnt1       = pick1;
                fifo_din   = pick1 ? data1 : data0;
                next_state = R_PRI;
            end else if (do_rd) begin
                fifo_rn    = 1'b1;
                rd_ack     = 1'b1;
                next_state = W_PRI;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= W_PRI;
            rr       <= 1'b0;
            rd_valid <= 1'b0;
            level    <= 4'd0;
        end else begin
            state    <= next_state;
            rd_valid <= do_rd;
            if (do_wr) begin
                rr <= ~pick1;
            end
            // Saturating guard; the FIFO flags should already prevent over/underflow.
            if (do_wr && level != 4'd8) begin
                level <= level + 4'd1;
            end else if (do_rd && level != 4'd0) begin
                level <= level - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed self-checking bench for fifo_access_scheduler; FIFO flags are driven
// directly by the bench and expected values are hand-computed per vector.
module tb_fifo_access_scheduler;

    logic       clock;
    logic       reset;
    logic       req0, req1, rd_req;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, rd_ack, rd_valid;
    logic       fifo_full, fifo_empty;
    logic       fifo_wn, fifo_rn;
    logic [7:0] fifo_din;
    logic [3:0] level;
    logic [4:0] en;

    int tests = 0;
    int fails = 0;

    fifo_access_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .req0       (req0),
        .data0      (data0),
        .req1       (req1),
        .data1      (data1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_wn    (fifo_wn),
        .fifo_din   (fifo_din),
        .fifo_rn    (fifo_rn),
        .level      (level)
    );

    // Enable bundle: {gnt0, gnt1, fifo_wn, fifo_rn, rd_ack}
    assign en = {gnt0, gnt1, fifo_wn, fifo_rn, rd_ack};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
        data0 = 8'h00; data1 = 8'h00; fifo_full = 1'b0; fifo_empty = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1; req0 = 1'b1; data0 = 8'h3C; rd_req = 1'b1; fifo_empty = 1'b0;
        #1;
        tests++;
        if (en !== 5'b00000 || fifo_din !== 8'h00) begin
            fails++;
            $display("FAIL reset_comb: en=%b din=%h, want en=00000 din=00", en, fifo_din);
        end
        tick();
        tests++;
        if (rd_valid !== 1'b0 || level !== 4'd0) begin
            fails++;
            $display("FAIL reset_regs: rd_valid=%b level=%0d, want 0 0", rd_valid, level);
        end
        req0 = 1'b0; rd_req = 1'b0; fifo_empty = 1'b1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_single_producer();
        do_reset();
        req0 = 1'b1; data0 = 8'h11;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (en !== 5'b10100 || fifo_din !== 8'h11) begin
                fails++;
                $display("FAIL single_en[%0d]: en=%b din=%h, want 10100 11", i, en, fifo_din);
            end
            tick();
            tests++;
            if (level !== 4'(i + 1)) begin
                fails++;
                $display("FAIL single_level[%0d]: level=%0d, want %0d", i, level, i + 1);
            end
        end
        req0 = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_en;
        logic [7:0] exp_din;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'hA0; data1 = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            exp_en  = (i % 2 == 0) ? 5'b10100 : 5'b01100;
            exp_din = (i % 2 == 0) ? 8'hA0 : 8'hB1;
            #1;
            tests++;
            if (en !== exp_en || fifo_din !== exp_din) begin
                fails++;
                $display("FAIL rr_grant[%0d]: en=%b din=%h, want %b %h", i, en, fifo_din, exp_en, exp_din);
            end
            tick();
        end
        tests++;
        if (level !== 4'd4) begin
            fails++;
            $display("FAIL rr_level: level=%0d, want 4", level);
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_en;
        logic [7:0] exp_din;
        logic [3:0] exp_level;
        do_reset();
        // Four writes then one read: level 3 and op priority back at W_PRI.
        req0 = 1'b1; data0 = 8'h42;
        repeat (4) tick();
        req0 = 1'b0; rd_req = 1'b1; fifo_empty = 1'b0;
        #1;
        tests++;
        if (en !== 5'b00011) begin
            fails++;
            $display("FAIL b2b_preread: en=%b, want 00011", en);
        end
        tick();
        tests++;
        if (rd_valid !== 1'b1 || level !== 4'd3) begin
            fails++;
            $display("FAIL b2b_preload: rd_valid=%b level=%0d, want 1 3", rd_valid, level);
        end
        req0 = 1'b1;
        exp_level = 4'd3;
        for (int i = 0; i < 4; i++) begin
            exp_en  = (i % 2 == 0) ? 5'b10100 : 5'b00011;
            exp_din = (i % 2 == 0) ? 8'h42 : 8'h00;
            #1;
            tests++;
            if (en !== exp_en || fifo_din !== exp_din) begin
                fails++;
                $display("FAIL b2b_issue[%0d]: en=%b din=%h, want %b %h", i, en, fifo_din, exp_en, exp_din);
            end
            tick();
            exp_level = (i % 2 == 0) ? exp_level + 4'd1 : exp_level - 4'd1;
            tests++;
            if (rd_valid !== (i % 2 == 1) || level !== exp_level) begin
                fails++;
                $display("FAIL b2b_after[%0d]: rd_valid=%b level=%0d, want %b %0d",
                         i, rd_valid, level, (i % 2 == 1), exp_level);
            end
        end
        req0 = 1'b0; rd_req = 1'b0; fifo_empty = 1'b1;
    endtask

    task automatic test_full_blocks();
        do_reset();
        req1 = 1'b1; data1 = 8'h5C;
        repeat (2) tick();
        fifo_full = 1'b1; fifo_empty = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (en !== 5'b00011) begin
                fails++;
                $display("FAIL full_read[%0d]: en=%b, want 00011", i, en);
            end
            tick();
        end
        tests++;
        if (level !== 4'd0) begin
            fails++;
            $display("FAIL full_level: level=%0d, want 0", level);
        end
        fifo_full = 1'b0;
        #1;
        tests++;
        if (en !== 5'b01100 || fifo_din !== 8'h5C) begin
            fails++;
            $display("FAIL full_release: en=%b din=%h, want 01100 5c", en, fifo_din);
        end
        tick();
        tests++;
        if (level !== 4'd1 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_after: level=%0d rd_valid=%b, want 1 0", level, rd_valid);
        end
        req1 = 1'b0; rd_req = 1'b0; fifo_empty = 1'b1;
    endtask

    task automatic test_empty_blocks();
        do_reset();
        fifo_empty = 1'b1; rd_req = 1'b1;
        #1;
        tests++;
        if (en !== 5'b00000) begin
            fails++;
            $display("FAIL empty_en: en=%b, want 00000", en);
        end
        tick();
        tests++;
        if (rd_valid !== 1'b0 || level !== 4'd0) begin
            fails++;
            $display("FAIL empty_after: rd_valid=%b level=%0d, want 0 0", rd_valid, level);
        end
        rd_req = 1'b0;
    endtask

    task automatic test_level_limit();
        do_reset();
        req0 = 1'b1; data0 = 8'h77;
        repeat (8) tick();
        tests++;
        if (level !== 4'd8) begin
            fails++;
            $display("FAIL limit_fill: level=%0d, want 8", level);
        end
        // Flag left low on purpose: the counter itself must not pass 8.
        tick();
        tests++;
        if (level !== 4'd8) begin
            fails++;
            $display("FAIL limit_sat: level=%0d, want 8", level);
        end
        fifo_full = 1'b1;
        #1;
        tests++;
        if (en !== 5'b00000) begin
            fails++;
            $display("FAIL limit_full_en: en=%b, want 00000", en);
        end
        req0 = 1'b0; fifo_full = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req0 = 1'b1; data0 = 8'h99;
        tick();
        req0 = 1'b0; rd_req = 1'b1; fifo_empty = 1'b0;
        #1;
        tests++;
        if (en !== 5'b00011) begin
            fails++;
            $display("FAIL midrd_ack: en=%b, want 00011", en);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (en !== 5'b00000 || fifo_din !== 8'h00) begin
            fails++;
            $display("FAIL midrd_forced: en=%b din=%h, want 00000 00", en, fifo_din);
        end
        tick();
        tests++;
        if (rd_valid !== 1'b0 || level !== 4'd0 || en !== 5'b00000) begin
            fails++;
            $display("FAIL midrd_after: rd_valid=%b level=%0d en=%b, want 0 0 00000", rd_valid, level, en);
        end
        reset = 1'b0; rd_req = 1'b0; fifo_empty = 1'b1;
        #1;
    endtask

    initial begin
        test_reset();
        test_single_producer();
        test_round_robin();
        test_back_to_back();
        test_full_blocks();
        test_empty_blocks();
        test_level_limit();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
